bp_stream_axil_bridge: RTL

//  FPGA-shell AXI-Lite slave that converts host PCIe/AXI-Lite transactions into the addressed stream

---
 rtl/bp_stream_pkg.sv | 27 ++
 rtl/bp_stream_axil_wr_fsm.sv | 102 ++++++++++
 rtl/bsg_fifo_1r1w_small.sv | 46 ++++
 rtl/bp_stream_axil_bridge.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bp_stream_pkg.sv
// Shared constants and types for the BlackParrot stream host AXI-Lite bridge.
package bp_stream_pkg;

   localparam logic [31:0] nbf_addr_gp      = 32'h10;
   localparam logic [31:0] mmio_addr_gp     = 32'h20;
   localparam logic [31:0] rd_data_addr_gp  = 32'h30;
   localparam logic [31:0] rd_count_addr_gp = 32'h34;
   localparam logic [31:0] status_addr_gp   = 32'h38;

   typedef enum logic [1:0] {
      e_axil_okay   = 2'b00,
      e_axil_slverr = 2'b10,
      e_axil_decerr = 2'b11
   } axil_resp_e;

   typedef enum logic [1:0] {
      e_w_collect = 2'd0,
      e_w_send    = 2'd1,
      e_w_resp    = 2'd2
   } wr_state_e;

   typedef enum logic {
      e_r_idle = 1'b0,
      e_r_resp = 1'b1
   } rd_state_e;

endpackage

// File: rtl/bp_stream_axil_wr_fsm.sv
// AXI-Lite write side: joins AW and W, forwards one stream word, then answers on B.
module bp_stream_axil_wr_fsm
   import bp_stream_pkg::*;
#(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [addr_width_p-1:0]   awaddr_i,
   input  logic                      awvalid_i,
   output logic                      awready_o,
   input  logic [data_width_p-1:0]   wdata_i,
   input  logic [data_width_p/8-1:0] wstrb_i,
   input  logic                      wvalid_i,
   output logic                      wready_o,
   output logic [1:0]                bresp_o,
   output logic                      bvalid_o,
   input  logic                      bready_i,
   output logic                      stream_v_o,
   output logic [addr_width_p-1:0]   stream_addr_o,
   output logic [data_width_p-1:0]   stream_data_o,
   input  logic                      stream_yumi_i,
   output logic                      busy_o
);

   wr_state_e                 state;
   axil_resp_e                bresp;
   logic                      aw_full;
   logic                      w_full;
   logic [addr_width_p-1:0]   addr;
   logic [data_width_p-1:0]   data;
   logic [data_width_p/8-1:0] strb;
   logic                      aw_hs;
   logic                      w_hs;
   logic [data_width_p/8-1:0] strb_now;

   assign awready_o     = (state == e_w_collect) & ~aw_full;
   assign wready_o      = (state == e_w_collect) & ~w_full;
   assign aw_hs         = awvalid_i & awready_o;
   assign w_hs          = wvalid_i & wready_o;
   assign strb_now      = w_full ? strb : wstrb_i;
   assign stream_v_o    = (state == e_w_send);
   assign stream_addr_o = addr;
   assign stream_data_o = data;
   assign bvalid_o      = (state == e_w_resp);
   assign bresp_o       = bresp;
   assign busy_o        = (state != e_w_collect);

   // Partial-strobe writes cannot be forwarded as whole stream words, so they are rejected.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state   <= e_w_collect;
         bresp   <= e_axil_okay;
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         addr    <= '0;
         data    <= '0;
         strb    <= '0;
      end else begin
         case (state)
            e_w_collect: begin
               if (aw_hs) begin
                  addr    <= awaddr_i;
                  aw_full <= 1'b1;
               end
               if (w_hs) begin
                  data   <= wdata_i;
                  strb   <= wstrb_i;
                  w_full <= 1'b1;
               end
               if ((aw_full | aw_hs) && (w_full | w_hs)) begin
                  if (&strb_now) begin
                     state <= e_w_send;
                  end else begin
                     bresp <= e_axil_slverr;
                     state <= e_w_resp;
                  end
               end
            end
            e_w_send: begin
               if (stream_yumi_i) begin
                  bresp <= e_axil_okay;
                  state <= e_w_resp;
               end
            end
            e_w_resp: begin
               if (bready_i) begin
                  aw_full <= 1'b0;
                  w_full  <= 1'b0;
                  addr    <= '0;
                  data    <= '0;
                  strb    <= '0;
                  state   <= e_w_collect;
               end
            end
            default: state <= e_w_collect;
         endcase
      end
   end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-array FIFO holding words returned by the stream host.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 32,
   parameter int els_p   = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w = $clog2(els_p);

   logic [width_p-1:0] mem [els_p];
   logic [ptr_w:0]     wptr;
   logic [ptr_w:0]     rptr;
   logic               enq;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign enq     = v_i & ready_o;
   assign v_o     = (wptr != rptr);
   assign ready_o = ~((wptr[ptr_w] != rptr[ptr_w]) && (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]));
   assign data_o  = mem[rptr[ptr_w-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (enq)
            wptr <= wptr + 1'b1;
         if (yumi_i)
            rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq)
         mem[wptr[ptr_w-1:0]] <= data_i;
   end

endmodule

// File: rtl/bp_stream_axil_bridge.sv
// AXI-Lite slave bridging host writes onto the BlackParrot stream host and
// buffering returned stream words for polled AXI-Lite reads.
module bp_stream_axil_bridge
   import bp_stream_pkg::*;
#(
   parameter int axil_addr_width_p = 32,
   parameter int axil_data_width_p = 32,
   parameter int rd_fifo_els_p     = 16
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
   input  logic                           s_axil_awvalid_i,
   output logic                           s_axil_awready_o,
   input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
   input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
   input  logic                           s_axil_wvalid_i,
   output logic                           s_axil_wready_o,
   output logic [1:0]                     s_axil_bresp_o,
   output logic                           s_axil_bvalid_o,
   input  logic                           s_axil_bready_i,
   input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
   input  logic                           s_axil_arvalid_i,
   output logic                           s_axil_arready_o,
   output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
   output logic [1:0]                     s_axil_rresp_o,
   output logic                           s_axil_rvalid_o,
   input  logic                           s_axil_rready_i,
   output logic                           stream_v_o,
   output logic [axil_addr_width_p-1:0]   stream_addr_o,
   output logic [axil_data_width_p-1:0]   stream_data_o,
   input  logic                           stream_yumi_i,
   input  logic                           stream_v_i,
   input  logic [axil_data_width_p-1:0]   stream_data_i,
   output logic                           stream_ready_o
);

   localparam int cnt_w = $clog2(rd_fifo_els_p + 1);

   logic                         wr_busy;
   logic                         fifo_ready;
   logic                         fifo_v;
   logic                         fifo_enq;
   logic [axil_data_width_p-1:0] fifo_data;
   logic                         pop;
   logic [cnt_w-1:0]             count;
   rd_state_e                    r_state;
   logic                         ar_hs;
   logic [axil_data_width_p-1:0] rdata;
   logic [axil_data_width_p-1:0] next_rdata;
   axil_resp_e                   rresp;
   axil_resp_e                   next_rresp;

   bp_stream_axil_wr_fsm #(
      .addr_width_p(axil_addr_width_p),
      .data_width_p(axil_data_width_p)
   ) wr_fsm (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .awaddr_i     (s_axil_awaddr_i),
      .awvalid_i    (s_axil_awvalid_i),
      .awready_o    (s_axil_awready_o),
      .wdata_i      (s_axil_wdata_i),
      .wstrb_i      (s_axil_wstrb_i),
      .wvalid_i     (s_axil_wvalid_i),
      .wready_o     (s_axil_wready_o),
      .bresp_o      (s_axil_bresp_o),
      .bvalid_o     (s_axil_bvalid_o),
      .bready_i     (s_axil_bready_i),
      .stream_v_o   (stream_v_o),
      .stream_addr_o(stream_addr_o),
      .stream_data_o(stream_data_o),
      .stream_yumi_i(stream_yumi_i),
      .busy_o       (wr_busy)
   );

   assign stream_ready_o = fifo_ready;
   assign fifo_enq       = stream_v_i & fifo_ready;

   bsg_fifo_1r1w_small #(
      .width_p(axil_data_width_p),
      .els_p  (rd_fifo_els_p)
   ) rd_fifo (
      .clk_i  (clk_i),
      .reset_i(~reset_n_i),
      .v_i    (stream_v_i),
      .ready_o(fifo_ready),
      .data_i (stream_data_i),
      .v_o    (fifo_v),
      .data_o (fifo_data),
      .yumi_i (pop)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i)
         count <= '0;
      else if (fifo_enq && !pop)
         count <= count + cnt_w'(1);
      else if (pop && !fifo_enq)
         count <= count - cnt_w'(1);
   end

   assign s_axil_arready_o = (r_state == e_r_idle);
   assign ar_hs            = s_axil_arvalid_i & s_axil_arready_o;

   // Empty-FIFO reads look only at the registered head, so a word arriving this cycle is not bypassed.
   always_comb begin
      next_rdata = '0;
      next_rresp = e_axil_decerr;
      pop        = 1'b0;
      if (s_axil_araddr_i == axil_addr_width_p'(rd_data_addr_gp)) begin
         if (fifo_v) begin
            pop        = ar_hs;
            next_rdata = fifo_data;
            next_rresp = e_axil_okay;
         end else begin
            next_rresp = e_axil_slverr;
         end
      end else if (s_axil_araddr_i == axil_addr_width_p'(rd_count_addr_gp)) begin
         next_rdata = axil_data_width_p'(count);
         next_rresp = e_axil_okay;
      end else if (s_axil_araddr_i == axil_addr_width_p'(status_addr_gp)) begin
         next_rdata = axil_data_width_p'({wr_busy, ~fifo_ready, ~fifo_v});
         next_rresp = e_axil_okay;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= e_r_idle;
         rdata   <= '0;
         rresp   <= e_axil_okay;
      end else begin
         case (r_state)
            e_r_idle: begin
               if (ar_hs) begin
                  rdata   <= next_rdata;
                  rresp   <= next_rresp;
                  r_state <= e_r_resp;
               end
            end
            e_r_resp: begin
               if (s_axil_rready_i)
                  r_state <= e_r_idle;
            end
            default: r_state <= e_r_idle;
         endcase
      end
   end

   assign s_axil_rvalid_o = (r_state == e_r_resp);
   assign s_axil_rdata_o  = rdata;
   assign s_axil_rresp_o  = rresp;

endmodule
